// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM + MEM/WB operand forwarding (enabled by ID_EX_FWD_EN).
// Latency: 1 cycle id_* -> ex_*; forwarding muxes and load_use_stall are combinational.
// Backpressure: stall freezes the stage, flush or load_use_stall loads a bubble (flush > stall > load-use).
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alu_src,
    input  logic              id_uses_rt,
    input  logic [2:0]        id_alu_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [2:0]        ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              alu_src;
        logic [2:0]        alu_ctrl;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_slot_t;

    ex_slot_t          r_ex;
    ex_slot_t          w_id_slot;
    logic              w_load_use;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    // An empty decode slot still captures its data, but must never write anything downstream.
    always_comb begin
        w_id_slot           = '0;
        w_id_slot.valid     = id_valid;
        w_id_slot.rs_data   = id_rs_data;
        w_id_slot.rt_data   = id_rt_data;
        w_id_slot.imm       = id_imm;
        w_id_slot.rs        = id_rs;
        w_id_slot.rt        = id_rt;
        w_id_slot.rd        = id_rd;
        w_id_slot.alu_src   = id_alu_src;
        w_id_slot.alu_ctrl  = id_alu_ctrl;
        w_id_slot.reg_write = id_valid & id_reg_write;
        w_id_slot.mem_read  = id_valid & id_mem_read;
        w_id_slot.mem_write = id_valid & id_mem_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (flush) begin
            r_ex <= '0;
        end else if (!stall) begin
            if (w_load_use) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_id_slot;
            end
        end
    end

`ifdef ID_EX_FWD_EN
    // Youngest producer wins; R0 is hard-wired zero so it is never a forwarding target.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] reg_val,
        input logic              em_we,
        input logic [REG_AW-1:0] em_rd,
        input logic [DATA_W-1:0] em_res,
        input logic              mw_we,
        input logic [REG_AW-1:0] mw_rd,
        input logic [DATA_W-1:0] mw_res
    );
        logic [DATA_W-1:0] sel;
        sel = reg_val;
        if (src != '0) begin
            if (em_we && (em_rd == src)) begin
                sel = em_res;
            end else if (mw_we && (mw_rd == src)) begin
                sel = mw_res;
            end
        end
        return sel;
    endfunction

    assign w_fwd_a = fwd_sel(r_ex.rs, r_ex.rs_data, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result);
    assign w_fwd_b = fwd_sel(r_ex.rt, r_ex.rt_data, exmem_reg_write, exmem_rd, exmem_result,
                             memwb_reg_write, memwb_rd, memwb_result);

    // A load result is not available to forward until MEM/WB, so the consumer waits one cycle.
    assign w_load_use = ~stall & ~flush & r_ex.valid & r_ex.mem_read & id_valid
                      & (r_ex.rd != '0)
                      & ((r_ex.rd == id_rs) | (id_uses_rt & (r_ex.rd == id_rt)));
`else
    assign w_fwd_a    = r_ex.rs_data;
    assign w_fwd_b    = r_ex.rt_data;
    assign w_load_use = 1'b0;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
                            memwb_rd, memwb_result, id_uses_rt, r_ex.rs, r_ex.rt};
`endif

    assign ex_valid       = r_ex.valid;
    assign ex_a           = w_fwd_a;
    assign ex_b           = r_ex.alu_src ? r_ex.imm : w_fwd_b;
    assign ex_store_data  = w_fwd_b;
    assign ex_alu_ctrl    = r_ex.alu_ctrl;
    assign ex_rd          = r_ex.rd;
    assign ex_reg_write   = r_ex.reg_write;
    assign ex_mem_read    = r_ex.mem_read;
    assign ex_mem_write   = r_ex.mem_write;
    assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed tables, multi-cycle hazard sequences, randomized model check.
module tb_id_ex_stage;
`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic        id_alu_src, id_uses_rt;
    logic [2:0]  id_alu_ctrl;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [3:0]  exmem_rd, memwb_rd;
    logic [15:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
    logic [15:0] ex_a, ex_b, ex_store_data;
    logic [2:0]  ex_alu_ctrl;
    logic [3:0]  ex_rd;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_src(id_alu_src),
        .id_uses_rt(id_uses_rt), .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rs, rt;
        logic [15:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic        em_we;
        logic [3:0]  em_rd;
        logic [15:0] em_res;
        logic        mw_we;
        logic [3:0]  mw_rd;
        logic [15:0] mw_res;
        logic [15:0] exp_a, exp_b, exp_sd;
    } fvec_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rs, rt, rd;
        logic [15:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic [2:0]  ctrl;
        logic        rw, mr, mw;
    } mslot_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_alu_src = 0; id_uses_rt = 0; id_alu_ctrl = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    // Reference operand value: what the ALU should see given the producers in flight.
    function automatic logic [15:0] ref_operand(input logic [3:0] src, input logic [15:0] reg_val);
        if (!FWD || src == 4'd0) return reg_val;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return reg_val;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, ex_valid, 0);
        check({tag, "_rw"},    ex_reg_write, 0);
        check({tag, "_mr"},    ex_mem_read, 0);
        check({tag, "_mw"},    ex_mem_write, 0);
        check({tag, "_ctrl"},  ex_alu_ctrl, 0);
        check({tag, "_rd"},    ex_rd, 0);
        check({tag, "_a"},     ex_a, 0);
        check({tag, "_lus"},   load_use_stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fvec_t  tbl[6];
        mslot_t m, nxt;
        logic   exp_lus;

        tbl[0] = '{4'd3, 4'd4, 16'h0000, 16'h0044, 16'h0000, 1'b0,
                   1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000, 16'h1234, 16'h0044, 16'h0044};
        tbl[1] = '{4'd5, 4'd5, 16'h0101, 16'h0202, 16'h0000, 1'b0,
                   1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'h5555, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        tbl[2] = '{4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0007, 1'b1,
                   1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 16'h1111, 16'h0000, 16'h0007, 16'h0000};
        tbl[3] = '{4'd6, 4'd7, 16'h0006, 16'h0007, 16'h0000, 1'b0,
                   1'b1, 4'd9, 16'h9999, 1'b1, 4'd7, 16'h7777, 16'h0006, 16'h7777, 16'h7777};
        tbl[4] = '{4'd8, 4'd8, 16'h0808, 16'h0880, 16'h0000, 1'b0,
                   1'b0, 4'd8, 16'hBEEF, 1'b0, 4'd8, 16'hCAFE, 16'h0808, 16'h0880, 16'h0880};
        tbl[5] = '{4'd2, 4'd2, 16'h0002, 16'h0022, 16'hFFF0, 1'b1,
                   1'b1, 4'd2, 16'h2222, 1'b1, 4'd2, 16'h5A5A, 16'h2222, 16'hFFF0, 16'h2222};

        // Power-on reset
        clear_inputs();
        rst_n = 0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Asynchronous reset while a valid instruction sits in EX
        id_valid = 1; id_rd = 5; id_reg_write = 1; id_alu_ctrl = 3'd3; id_rs = 1; id_rs_data = 16'h00AB;
        tick();
        check("pre_rst_valid", ex_valid, 1);
        check("pre_rst_a", ex_a, 16'h00AB);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1;
        clear_inputs();

        // Forwarding table
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            id_valid = 1; id_rs = tbl[i].rs; id_rt = tbl[i].rt;
            id_rs_data = tbl[i].rs_data; id_rt_data = tbl[i].rt_data;
            id_imm = tbl[i].imm; id_alu_src = tbl[i].alu_src; id_uses_rt = 1;
            tick();
            id_valid = 0;
            exmem_reg_write = tbl[i].em_we; exmem_rd = tbl[i].em_rd; exmem_result = tbl[i].em_res;
            memwb_reg_write = tbl[i].mw_we; memwb_rd = tbl[i].mw_rd; memwb_result = tbl[i].mw_res;
            #1;
            check($sformatf("fwd%0d_a", i), ex_a, FWD ? tbl[i].exp_a : tbl[i].rs_data);
            check($sformatf("fwd%0d_b", i), ex_b,
                  FWD ? tbl[i].exp_b : (tbl[i].alu_src ? tbl[i].imm : tbl[i].rt_data));
            check($sformatf("fwd%0d_sd", i), ex_store_data, FWD ? tbl[i].exp_sd : tbl[i].rt_data);
        end

        // Load-use: load to r2 in EX, consumer reading r2 in ID
        clear_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 2; id_rs = 4;
        tick();
        id_mem_read = 0; id_rd = 6; id_rs = 7; id_rt = 2; id_uses_rt = 0; id_rs_data = 0;
        #1;
        check("lu_rt_unused", load_use_stall, 0);
        id_uses_rt = 1;
        #1;
        check("lu_rt", load_use_stall, FWD);
        id_uses_rt = 0; id_rs = 2;
        #1;
        check("lu_rs", load_use_stall, FWD);
        tick();
        check("lu_bubble_valid", ex_valid, !FWD);
        check("lu_bubble_rw", ex_reg_write, !FWD);
        check("lu_once", load_use_stall, 0);
        memwb_reg_write = 1; memwb_rd = 2; memwb_result = 16'h4242;
        tick();
        check("lu_replay_valid", ex_valid, 1);
        check("lu_replay_rd", ex_rd, 6);
        check("lu_replay_a", ex_a, FWD ? 16'h4242 : 16'h0000);

        // Stall holds for 3 cycles; stall+flush loads a bubble
        clear_inputs();
        id_valid = 1; id_rd = 9; id_rs = 3; id_rs_data = 16'h3333; id_alu_ctrl = 3'd5;
        id_mem_read = 1; id_reg_write = 1;
        tick();
        stall = 1; id_rs = 9; id_rd = 1; id_rs_data = 16'h1111; id_alu_ctrl = 3'd1; id_mem_read = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d_valid", c), ex_valid, 1);
            check($sformatf("stall%0d_rd", c), ex_rd, 9);
            check($sformatf("stall%0d_a", c), ex_a, 16'h3333);
            check($sformatf("stall%0d_ctrl", c), ex_alu_ctrl, 5);
            check($sformatf("stall%0d_lus", c), load_use_stall, 0);
        end
        flush = 1;
        #1;
        check("sf_lus", load_use_stall, 0);
        tick();
        check("sf_valid", ex_valid, 0);
        check("sf_rw", ex_reg_write, 0);
        check("sf_mr", ex_mem_read, 0);
        check("sf_mw", ex_mem_write, 0);
        check("sf_a", ex_a, 0);
        check("sf_rd", ex_rd, 0);

        // Randomized run against the reference model
        clear_inputs();
        flush = 1;
        tick();
        m = '0;
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs = 4'($urandom_range(0, 3)); id_rt = 4'($urandom_range(0, 3));
            id_rd = 4'($urandom_range(0, 3));
            id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
            id_alu_src = 1'($urandom); id_uses_rt = 1'($urandom); id_alu_ctrl = 3'($urandom_range(0, 5));
            id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom);
            exmem_reg_write = 1'($urandom); exmem_rd = 4'($urandom_range(0, 3));
            exmem_result = 16'($urandom);
            memwb_reg_write = 1'($urandom); memwb_rd = 4'($urandom_range(0, 3));
            memwb_result = 16'($urandom);
            #1;
            exp_lus = FWD && !stall && !flush && m.valid && m.mr && id_valid && m.rd != 0 &&
                      (m.rd == id_rs || (id_uses_rt && m.rd == id_rt));
            check("rnd_lus", load_use_stall, exp_lus);
            check("rnd_valid", ex_valid, m.valid);
            check("rnd_rw", ex_reg_write, m.rw);
            check("rnd_mr", ex_mem_read, m.mr);
            check("rnd_mw", ex_mem_write, m.mw);
            if (m.valid) begin
                check("rnd_rd", ex_rd, m.rd);
                check("rnd_ctrl", ex_alu_ctrl, m.ctrl);
                check("rnd_a", ex_a, ref_operand(m.rs, m.rs_data));
                check("rnd_b", ex_b, m.alu_src ? m.imm : ref_operand(m.rt, m.rt_data));
                check("rnd_sd", ex_store_data, ref_operand(m.rt, m.rt_data));
            end
            if (flush || (!stall && exp_lus)) begin
                nxt = '0;
            end else if (stall) begin
                nxt = m;
            end else begin
                nxt = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                        rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
                        alu_src: id_alu_src, ctrl: id_alu_ctrl,
                        rw: id_valid && id_reg_write, mr: id_valid && id_mem_read,
                        mw: id_valid && id_mem_write};
            end
            tick();
            m = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding logic. It sits directly upstream of the 16-bit main ALU.
- Captures decoded operands and control from the decode stage each cycle.
- Resolves EX/MEM and MEM/WB data hazards by forwarding, and drives the ALU inputs A, B and ALUControl.
- Detects load-use hazards and inserts a single bubble.

Parameters:
- DATA_W, 16, operand/result width (ALU is 16-bit)
- REG_AW, 4, register-address width (16 registers; R0 reads as zero)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  global hold (e.g. memory wait); freezes the stage
- flush  in  1  branch/jump squash; loads a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data  in  DATA_W  register-file read port A
- id_rt_data  in  DATA_W  register-file read port B
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW each  source/destination register numbers
- id_alu_src  in  1  1: B operand = immediate
- id_uses_rt  in  1  instruction reads rt (register operand or store data)
- id_alu_ctrl  in  3  ALU opcode, encoding as MainALU (000 add … 101 or)
- id_reg_write, id_mem_read, id_mem_write  in  1 each  downstream control
- exmem_reg_write  in  1  EX/MEM will write a register
- exmem_rd  in  REG_AW  EX/MEM destination register
- exmem_result  in  DATA_W  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB will write a register
- memwb_rd  in  REG_AW  MEM/WB destination register
- memwb_result  in  DATA_W  MEM/WB write-back data
- ex_valid  out  1  EX slot holds a real instruction
- ex_a  out  DATA_W  ALU input A (forwarded)
- ex_b  out  DATA_W  ALU input B (forwarded register or immediate)
- ex_alu_ctrl  out  3  ALU opcode
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_rd  out  REG_AW  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control, all forced 0 for a bubble
- load_use_stall  out  1  request to hold PC and IF/ID for one cycle

Behaviour:
- Reset (async, rst_n=0):
  - All stage registers clear to 0; ex_valid=0; all ex_* control outputs 0.
  - ex_alu_ctrl=000; ex_rd=0.
  - Takes effect immediately mid-operation; the in-flight instruction is discarded.
- Register-update priority each rising edge: flush > stall > load_use_stall > normal load.
  - flush=1: load bubble (valid=0, control 0, data 0). Overrides stall.
  - stall=1: hold all registers unchanged.
  - load_use_stall=1: load bubble. IF/ID holds externally, so the same decode is presented again next cycle.
  - Otherwise: capture all id_* inputs; valid=id_valid. If id_valid=0, control is forced to 0.
- Bubble definition: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0. A bubble is never a forwarding or hazard source.
- load_use_stall (combinational) = ex_valid & ex_mem_read & id_valid & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)). It is gated to 0 while stall or flush is asserted.
- Forwarding (combinational, applied to registered rs/rt values), per operand:
  - EX/MEM match (exmem_reg_write & exmem_rd!=0 & exmem_rd==src) selects exmem_result.
  - Else MEM/WB match selects memwb_result.
  - Else the registered read data is used.
  - EX/MEM has priority when both stages match.
- Source register 0 is never forwarded; the registered value is passed through (register file returns 0).
- ex_b = registered alu_src ? registered imm : forwarded rt. ex_store_data is always the forwarded rt.
- Latency: one cycle from id_* to ex_*. Forwarding adds no cycles.
- No arithmetic in this block; widths pass through unchanged.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - ex_a, ex_b and ex_store_data use the registered read data only; exmem_*/memwb_* inputs are ignored.
  - load_use_stall is tied to 0.
  - Software must schedule NOPs.

Test Plan:
- Reset mid-stream: rst_n low asynchronously while ex_valid=1 -> all outputs 0 immediately, without waiting for a clk edge.
- Back-to-back RAW: EX/MEM holds rd=3, result 0x1234, reg_write=1; ID/EX captured rs=3, id_rs_data=0x0000 -> ex_a=0x1234.
- Double match: exmem_rd=memwb_rd=5 with results 0xAAAA/0x5555; rs=rt=5, alu_src=0 -> ex_a=ex_b=0xAAAA.
- R0 and immediate: rs=0, exmem_rd=0, reg_write=1, result 0xFFFF -> ex_a equals registered data 0x0000. alu_src=1 with imm=0x0007 -> ex_b=0x0007.
- Load-use: EX holds a load with rd=2; ID rs=2 -> load_use_stall=1 for one cycle, next cycle ex_valid=0. The re-presented instruction then gets memwb_result forwarded.
- Stall vs flush: stall=1 holds ex_* for 3 cycles unchanged. stall=1 and flush=1 together -> bubble loaded, load_use_stall=0.
